// File: rtl/ll_flit_tx_bridge.sv
// Flit-network router port to Aurora LocalLink TX bridge: per-VC flit FIFOs,
// round-robin VC arbitration under remote credit, two-word frame per flit.
module ll_flit_tx_bridge #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [20:0] putFlit_flit_in,
  input  logic        EN_putFlit,
  output logic [1:0]  getNonFullVCs,
  input  logic [1:0]  remote_nonFullVCs,
  input  logic        CHANNEL_UP,
  output logic [15:0] TX_D,
  output logic        TX_REM,
  output logic        TX_SOF_N,
  output logic        TX_EOF_N,
  output logic        TX_SRC_RDY_N,
  input  logic        TX_DST_RDY_N,
  output logic        OVERFLOW
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

  logic [20:0]   r_mem  [2][FIFO_DEPTH];
  logic [AW-1:0] r_wptr [2];
  logic [AW-1:0] r_rptr [2];
  logic [CW-1:0] r_cnt  [2];
  logic [CW-1:0] w_cnt_nxt [2];
  logic [20:0]   w_head [2];
  logic [20:0]   w_head_cur_next;
  logic [1:0]    w_full, w_enq, w_pop, w_elig, w_elig_rem;
  logic [1:0]    r_nonfull;
  logic          r_ovf;

  state_t        r_state, w_state_nxt;
  logic          r_cur_vc, w_cur_vc_nxt;
  logic          r_rr, w_rr_nxt;
  logic          w_deq, w_start, w_go_idle, w_sel;
  logic [20:0]   w_hdr_flit;
  logic [15:0]   r_tx_d, w_tx_d_nxt;
  logic          r_rem, w_rem_nxt;
  logic          r_sof_n, w_sof_n_nxt;
  logic          r_eof_n, w_eof_n_nxt;
  logic          r_src_n, w_src_n_nxt;

  function automatic logic pick(input logic [1:0] e, input logic rr);
    return (e == 2'b11) ? rr : e[1];
  endfunction

  // w_elig_rem: eligibility as it stands once the current VC's head is popped
  always_comb begin
    for (int unsigned v = 0; v < 2; v++) begin
      w_full[v[0]]    = (r_cnt[v[0]] == CW'(FIFO_DEPTH));
      w_head[v[0]]    = r_mem[v[0]][r_rptr[v[0]]];
      w_enq[v[0]]     = EN_putFlit && putFlit_flit_in[20] &&
                        (putFlit_flit_in[16] == v[0]) && !w_full[v[0]];
      w_pop[v[0]]     = w_deq && (r_cur_vc == v[0]);
      w_elig[v[0]]    = (r_cnt[v[0]] != '0) && remote_nonFullVCs[v[0]] && CHANNEL_UP;
      w_elig_rem[v[0]] = (r_cur_vc == v[0]) ?
                         ((r_cnt[v[0]] > CW'(1)) && remote_nonFullVCs[v[0]] && CHANNEL_UP) :
                         w_elig[v[0]];
      w_cnt_nxt[v[0]] = r_cnt[v[0]] + CW'(w_enq[v[0]]) - CW'(w_pop[v[0]]);
    end
    w_head_cur_next = r_mem[r_cur_vc][r_rptr[r_cur_vc] + AW'(1)];
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cur_vc_nxt = r_cur_vc;
    w_rr_nxt     = r_rr;
    w_deq        = 1'b0;
    w_start      = 1'b0;
    w_go_idle    = 1'b0;
    w_sel        = 1'b0;
    w_hdr_flit   = w_head[0];
    w_tx_d_nxt   = r_tx_d;
    w_rem_nxt    = r_rem;
    w_sof_n_nxt  = r_sof_n;
    w_eof_n_nxt  = r_eof_n;
    w_src_n_nxt  = r_src_n;
    unique case (r_state)
      S_IDLE: begin
        if (|w_elig) begin
          w_start    = 1'b1;
          w_sel      = pick(w_elig, r_rr);
          w_hdr_flit = w_head[w_sel];
        end
      end
      S_HDR: begin
        if (!CHANNEL_UP) begin
          w_go_idle = 1'b1;
        end else if (!TX_DST_RDY_N) begin
          w_state_nxt = S_DATA;
          w_tx_d_nxt  = w_head[r_cur_vc][15:0];
          w_sof_n_nxt = 1'b1;
          w_eof_n_nxt = 1'b0;
        end
      end
      S_DATA: begin
        if (!CHANNEL_UP) begin
          w_go_idle = 1'b1;
        end else if (!TX_DST_RDY_N) begin
          w_deq    = 1'b1;
          w_rr_nxt = ~r_cur_vc;
          if (|w_elig_rem) begin
            w_start    = 1'b1;
            w_sel      = pick(w_elig_rem, ~r_cur_vc);
            w_hdr_flit = (w_sel == r_cur_vc) ? w_head_cur_next : w_head[w_sel];
          end else begin
            w_go_idle = 1'b1;
          end
        end
      end
      default: w_go_idle = 1'b1;
    endcase
    if (w_start) begin
      w_state_nxt  = S_HDR;
      w_cur_vc_nxt = w_sel;
      w_tx_d_nxt   = {11'b0, w_hdr_flit[20:16]};
      w_sof_n_nxt  = 1'b0;
      w_eof_n_nxt  = 1'b1;
      w_src_n_nxt  = 1'b0;
      w_rem_nxt    = 1'b1;
    end
    if (w_go_idle) begin
      w_state_nxt = S_IDLE;
      w_src_n_nxt = 1'b1;
      w_sof_n_nxt = 1'b1;
      w_eof_n_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    for (int unsigned v = 0; v < 2; v++) begin
      if (w_enq[v[0]]) r_mem[v[0]][r_wptr[v[0]]] <= putFlit_flit_in;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned v = 0; v < 2; v++) begin
        r_wptr[v[0]] <= '0;
        r_rptr[v[0]] <= '0;
        r_cnt[v[0]]  <= '0;
      end
      r_nonfull <= '1;
      r_ovf     <= 1'b0;
      r_state   <= S_IDLE;
      r_cur_vc  <= 1'b0;
      r_rr      <= 1'b0;
      r_tx_d    <= '0;
      r_rem     <= 1'b0;
      r_sof_n   <= 1'b1;
      r_eof_n   <= 1'b1;
      r_src_n   <= 1'b1;
    end else begin
      for (int unsigned v = 0; v < 2; v++) begin
        if (w_enq[v[0]]) r_wptr[v[0]] <= r_wptr[v[0]] + AW'(1);
        if (w_pop[v[0]]) r_rptr[v[0]] <= r_rptr[v[0]] + AW'(1);
        r_cnt[v[0]]     <= w_cnt_nxt[v[0]];
        r_nonfull[v[0]] <= (w_cnt_nxt[v[0]] != CW'(FIFO_DEPTH));
      end
      r_ovf    <= r_ovf | (EN_putFlit && putFlit_flit_in[20] && w_full[putFlit_flit_in[16]]);
      r_state  <= w_state_nxt;
      r_cur_vc <= w_cur_vc_nxt;
      r_rr     <= w_rr_nxt;
      r_tx_d   <= w_tx_d_nxt;
      r_rem    <= w_rem_nxt;
      r_sof_n  <= w_sof_n_nxt;
      r_eof_n  <= w_eof_n_nxt;
      r_src_n  <= w_src_n_nxt;
    end
  end

  assign getNonFullVCs = r_nonfull;
  assign OVERFLOW      = r_ovf;
  assign TX_D          = r_tx_d;
  assign TX_REM        = r_rem;
  assign TX_SOF_N      = r_sof_n;
  assign TX_EOF_N      = r_eof_n;
  assign TX_SRC_RDY_N  = r_src_n;

endmodule

// File: tb/tb_ll_flit_tx_bridge.sv
// Self-checking bench for ll_flit_tx_bridge: directed scenarios plus a
// randomized run scored against a queue-level model of the per-VC FIFOs.
module tb_ll_flit_tx_bridge;
  localparam int D = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [20:0] putFlit_flit_in = '0;
  logic        EN_putFlit = 1'b0;
  logic [1:0]  getNonFullVCs;
  logic [1:0]  remote_nonFullVCs = 2'b11;
  logic        CHANNEL_UP = 1'b0;
  logic [15:0] TX_D;
  logic        TX_REM, TX_SOF_N, TX_EOF_N, TX_SRC_RDY_N;
  logic        TX_DST_RDY_N = 1'b0;
  logic        OVERFLOW;

  int checks = 0;
  int failures = 0;
  logic [20:0] got[$];
  logic [20:0] expq[$];

  ll_flit_tx_bridge #(.FIFO_DEPTH(D)) dut (
    .CLK(CLK), .RESET(RESET),
    .putFlit_flit_in(putFlit_flit_in), .EN_putFlit(EN_putFlit),
    .getNonFullVCs(getNonFullVCs), .remote_nonFullVCs(remote_nonFullVCs),
    .CHANNEL_UP(CHANNEL_UP), .TX_D(TX_D), .TX_REM(TX_REM),
    .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N),
    .TX_SRC_RDY_N(TX_SRC_RDY_N), .TX_DST_RDY_N(TX_DST_RDY_N),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [20:0] mk(input logic vc, input logic [1:0] dest, input logic [15:0] d);
    return {1'b1, 1'b0, dest, vc, d};
  endfunction

  task automatic do_reset();
    RESET = 1'b0; EN_putFlit = 1'b0; putFlit_flit_in = '0;
    CHANNEL_UP = 1'b0; remote_nonFullVCs = 2'b11; TX_DST_RDY_N = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic put_flit(input logic [20:0] f);
    EN_putFlit = 1'b1; putFlit_flit_in = f;
    @(negedge CLK);
    EN_putFlit = 1'b0; putFlit_flit_in = '0;
  endtask

  task automatic wait_hdr(input string name);
    for (int k = 0; k < 6; k++) begin
      if (TX_SRC_RDY_N === 1'b0) break;
      @(negedge CLK);
    end
    checks++;
    if (TX_SRC_RDY_N !== 1'b0)
      $display("FAIL %s_hdr_timeout: src_rdy_n=%b required 0", name, TX_SRC_RDY_N);
  endtask

  // Gathers completed frames as reassembled flits; a data word must follow a header.
  task automatic collect(input int ncyc);
    logic [4:0] hdr;
    logic pend;
    got.delete();
    pend = 1'b0;
    hdr = '0;
    TX_DST_RDY_N = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (TX_SRC_RDY_N === 1'b0 && TX_SOF_N === 1'b0) begin
        hdr = TX_D[4:0];
        pend = 1'b1;
      end else if (TX_SRC_RDY_N === 1'b0 && TX_EOF_N === 1'b0) begin
        checks++;
        if (pend !== 1'b1) begin
          failures++;
          $display("FAIL frame_order: data word 0x%h without header", TX_D);
        end else begin
          got.push_back({hdr, TX_D});
        end
        pend = 1'b0;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (TX_SRC_RDY_N !== 1 || TX_SOF_N !== 1 || TX_EOF_N !== 1 || TX_D !== 16'h0 ||
        TX_REM !== 0 || getNonFullVCs !== 2'b11 || OVERFLOW !== 0) begin
      failures++;
      $display("FAIL reset_values: src=%b sof=%b eof=%b d=%h rem=%b nf=%b ovf=%b required 1 1 1 0000 0 11 0",
               TX_SRC_RDY_N, TX_SOF_N, TX_EOF_N, TX_D, TX_REM, getNonFullVCs, OVERFLOW);
    end
    for (int i = 0; i < 5; i++) put_flit(mk(1'b0, 2'b01, 16'h5000 + 16'(i)));
    checks++;
    if (OVERFLOW !== 1'b1 || getNonFullVCs !== 2'b10) begin
      failures++;
      $display("FAIL reset_prefill: ovf=%b nf=%b required 1 10", OVERFLOW, getNonFullVCs);
    end
    CHANNEL_UP = 1'b1;
    @(negedge CLK);
    wait_hdr("reset");
    if (TX_SRC_RDY_N !== 1'b0) failures++;
    #2 RESET = 1'b0;
    #1;
    checks++;
    if (TX_SRC_RDY_N !== 1 || TX_SOF_N !== 1 || getNonFullVCs !== 2'b11 || OVERFLOW !== 0 || TX_D !== 16'h0) begin
      failures++;
      $display("FAIL reset_async: src=%b sof=%b nf=%b ovf=%b d=%h required 1 1 11 0 0000",
               TX_SRC_RDY_N, TX_SOF_N, getNonFullVCs, OVERFLOW, TX_D);
    end
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    CHANNEL_UP = 1'b1;
    put_flit({1'b1, 1'b1, 2'b10, 1'b0, 16'hBEEF});
    checks++;
    if (TX_SRC_RDY_N !== 1'b1) begin
      failures++; $display("FAIL single_latency: src=%b required 1", TX_SRC_RDY_N);
    end
    @(negedge CLK);
    checks++;
    if (TX_D !== 16'h001C || TX_SOF_N !== 0 || TX_EOF_N !== 1 || TX_SRC_RDY_N !== 0 || TX_REM !== 1) begin
      failures++;
      $display("FAIL single_hdr: d=%h sof=%b eof=%b src=%b rem=%b required 001c 0 1 0 1",
               TX_D, TX_SOF_N, TX_EOF_N, TX_SRC_RDY_N, TX_REM);
    end
    @(negedge CLK);
    checks++;
    if (TX_D !== 16'hBEEF || TX_SOF_N !== 1 || TX_EOF_N !== 0 || TX_SRC_RDY_N !== 0 || TX_REM !== 1) begin
      failures++;
      $display("FAIL single_data: d=%h sof=%b eof=%b src=%b rem=%b required beef 1 0 0 1",
               TX_D, TX_SOF_N, TX_EOF_N, TX_SRC_RDY_N, TX_REM);
    end
    @(negedge CLK);
    checks++;
    if (TX_SRC_RDY_N !== 1'b1 || TX_SOF_N !== 1'b1 || TX_EOF_N !== 1'b1) begin
      failures++;
      $display("FAIL single_idle: src=%b sof=%b eof=%b required 1 1 1", TX_SRC_RDY_N, TX_SOF_N, TX_EOF_N);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    CHANNEL_UP = 1'b1;
    put_flit({1'b1, 1'b1, 2'b10, 1'b0, 16'hBEEF});
    @(negedge CLK);
    @(negedge CLK);
    TX_DST_RDY_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checks++;
      if (TX_D !== 16'hBEEF || TX_EOF_N !== 0 || TX_SRC_RDY_N !== 0 || TX_SOF_N !== 1) begin
        failures++;
        $display("FAIL bp_hold%0d: d=%h eof=%b src=%b required beef 0 0", k, TX_D, TX_EOF_N, TX_SRC_RDY_N);
      end
    end
    TX_DST_RDY_N = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      checks++;
      if (TX_SRC_RDY_N !== 1'b1) begin
        failures++;
        $display("FAIL bp_single_dequeue%0d: src=%b required 1", k, TX_SRC_RDY_N);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) put_flit(mk(1'b1, 2'b00, 16'h1000 + 16'(i)));
    checks++;
    if (getNonFullVCs !== 2'b01 || OVERFLOW !== 1'b0) begin
      failures++; $display("FAIL ovf_full: nf=%b ovf=%b required 01 0", getNonFullVCs, OVERFLOW);
    end
    put_flit(mk(1'b1, 2'b00, 16'h1004));
    checks++;
    if (OVERFLOW !== 1'b1 || getNonFullVCs !== 2'b01) begin
      failures++; $display("FAIL ovf_drop: ovf=%b nf=%b required 1 01", OVERFLOW, getNonFullVCs);
    end
    put_flit(mk(1'b0, 2'b11, 16'h0A0A));
    checks++;
    if (getNonFullVCs !== 2'b01) begin
      failures++; $display("FAIL ovf_vc0: nf=%b required 01", getNonFullVCs);
    end
    CHANNEL_UP = 1'b1;
    collect(20);
    expq.delete();
    expq.push_back(mk(1'b0, 2'b11, 16'h0A0A));
    for (int i = 0; i < 4; i++) expq.push_back(mk(1'b1, 2'b00, 16'h1000 + 16'(i)));
    checks++;
    if (got.size() != expq.size()) begin
      failures++; $display("FAIL ovf_count: frames=%0d required %0d", got.size(), expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        checks++;
        if (got[i] !== expq[i]) begin
          failures++; $display("FAIL ovf_frame%0d: got %h required %h", i, got[i], expq[i]);
        end
      end
    end
    checks++;
    if (OVERFLOW !== 1'b1) begin
      failures++; $display("FAIL ovf_sticky: ovf=%b required 1", OVERFLOW);
    end
  endtask

  task automatic test_arbitration();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      remote_nonFullVCs = (pass == 0) ? 2'b11 : 2'b10;
      put_flit(mk(1'b0, 2'b01, 16'hA000));
      put_flit(mk(1'b0, 2'b01, 16'hA001));
      put_flit(mk(1'b1, 2'b10, 16'hB000));
      put_flit(mk(1'b1, 2'b10, 16'hB001));
      CHANNEL_UP = 1'b1;
      collect(16);
      expq.delete();
      if (pass == 0) begin
        expq.push_back(mk(1'b0, 2'b01, 16'hA000));
        expq.push_back(mk(1'b1, 2'b10, 16'hB000));
        expq.push_back(mk(1'b0, 2'b01, 16'hA001));
        expq.push_back(mk(1'b1, 2'b10, 16'hB001));
      end else begin
        expq.push_back(mk(1'b1, 2'b10, 16'hB000));
        expq.push_back(mk(1'b1, 2'b10, 16'hB001));
      end
      checks++;
      if (got.size() != expq.size()) begin
        failures++; $display("FAIL arb%0d_count: frames=%0d required %0d", pass, got.size(), expq.size());
      end else begin
        for (int i = 0; i < expq.size(); i++) begin
          checks++;
          if (got[i] !== expq[i]) begin
            failures++; $display("FAIL arb%0d_frame%0d: got %h required %h", pass, i, got[i], expq[i]);
          end
        end
      end
    end
  endtask

  task automatic test_channel_drop();
    do_reset();
    for (int i = 0; i < 4; i++) put_flit(mk(1'b0, 2'b11, 16'hC000 + 16'(i)));
    CHANNEL_UP = 1'b1;
    @(negedge CLK);
    wait_hdr("cdrop");
    checks++;
    if (TX_SOF_N !== 1'b0 || TX_D !== 16'h0016) begin
      failures++; $display("FAIL cdrop_hdr: sof=%b d=%h required 0 0016", TX_SOF_N, TX_D);
    end
    CHANNEL_UP = 1'b0;
    @(negedge CLK);
    checks++;
    if (TX_SRC_RDY_N !== 1'b1 || getNonFullVCs !== 2'b10) begin
      failures++; $display("FAIL cdrop_abort: src=%b nf=%b required 1 10", TX_SRC_RDY_N, getNonFullVCs);
    end
    repeat (2) @(negedge CLK);
    CHANNEL_UP = 1'b1;
    collect(16);
    checks++;
    if (got.size() != 4) begin
      failures++; $display("FAIL cdrop_count: frames=%0d required 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== mk(1'b0, 2'b11, 16'hC000 + 16'(i))) begin
          failures++;
          $display("FAIL cdrop_frame%0d: got %h required %h", i, got[i], mk(1'b0, 2'b11, 16'hC000 + 16'(i)));
        end
      end
    end
  endtask

  logic [20:0] mq0[$];
  logic [20:0] mq1[$];
  logic        m_ovf;
  logic        m_cur;
  logic        m_in_data;

  task automatic run_random(input int ncyc, input bit enq_on);
    logic [20:0] f;
    logic        vc;
    logic [20:0] head;
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if (getNonFullVCs !== {mq1.size() < D, mq0.size() < D}) begin
        failures++;
        $display("FAIL rnd_nonfull c=%0d: nf=%b required %b", c, getNonFullVCs, {mq1.size() < D, mq0.size() < D});
      end
      checks++;
      if (OVERFLOW !== m_ovf) begin
        failures++; $display("FAIL rnd_overflow c=%0d: ovf=%b required %b", c, OVERFLOW, m_ovf);
      end
      if (TX_SRC_RDY_N === 1'b0) begin
        checks++;
        if (!m_in_data) begin
          vc = TX_D[0];
          head = (vc ? (mq1.size() > 0 ? mq1[0] : 'x) : (mq0.size() > 0 ? mq0[0] : 'x));
          if (TX_SOF_N !== 0 || TX_EOF_N !== 1 || TX_REM !== 1 || TX_D !== {11'b0, head[20:16]}) begin
            failures++;
            $display("FAIL rnd_hdr c=%0d: d=%h sof=%b eof=%b required %h 0 1", c, TX_D, TX_SOF_N, TX_EOF_N, {11'b0, head[20:16]});
          end
          m_cur = vc;
        end else begin
          head = m_cur ? mq1[0] : mq0[0];
          if (TX_SOF_N !== 1 || TX_EOF_N !== 0 || TX_REM !== 1 || TX_D !== head[15:0]) begin
            failures++;
            $display("FAIL rnd_data c=%0d: d=%h sof=%b eof=%b required %h 1 0", c, TX_D, TX_SOF_N, TX_EOF_N, head[15:0]);
          end
        end
      end
      TX_DST_RDY_N = enq_on ? ($urandom_range(0, 3) == 0) : 1'b0;
      EN_putFlit = enq_on && ($urandom_range(0, 9) < 6);
      f = 21'($urandom);
      f[20] = ($urandom_range(0, 9) != 0);
      putFlit_flit_in = f;
      if (EN_putFlit && f[20]) begin
        if (f[16]) begin
          if (mq1.size() == D) m_ovf = 1'b1; else mq1.push_back(f);
        end else begin
          if (mq0.size() == D) m_ovf = 1'b1; else mq0.push_back(f);
        end
      end
      if (TX_SRC_RDY_N === 1'b0 && !TX_DST_RDY_N) begin
        if (!m_in_data) m_in_data = 1'b1;
        else begin
          if (m_cur) void'(mq1.pop_front()); else void'(mq0.pop_front());
          m_in_data = 1'b0;
        end
      end
      @(negedge CLK);
    end
    EN_putFlit = 1'b0;
    putFlit_flit_in = '0;
  endtask

  task automatic test_random();
    do_reset();
    CHANNEL_UP = 1'b1;
    mq0.delete(); mq1.delete();
    m_ovf = 1'b0; m_cur = 1'b0; m_in_data = 1'b0;
    run_random(400, 1'b1);
    run_random(60, 1'b0);
    checks++;
    if (mq0.size() != 0 || mq1.size() != 0 || TX_SRC_RDY_N !== 1'b1) begin
      failures++;
      $display("FAIL rnd_drain: left vc0=%0d vc1=%0d src=%b required 0 0 1", mq0.size(), mq1.size(), TX_SRC_RDY_N);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_arbitration();
    test_channel_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
